hb_task_scheduler: RTL and testbench

HB_TASK_SCHEDULER -- requirements
Module: hb_task_scheduler

---
 rtl/hb_task_pkg.sv | 12 +
 rtl/hb_rr_arbiter.sv | 32 +++
 rtl/hb_task_scheduler.sv | 165 ++++++++++++++++
 tb/tb_hb_task_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hb_task_pkg.sv
// Shared types and constants for the task scheduler: dispatcher state
// encoding and the handoff counter width.
package hb_task_pkg;

  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } disp_state_e;

endpackage

// File: rtl/hb_rr_arbiter.sv
// Combinational round-robin selector: picks the first requester at or after
// ptr (wrapping) and reports it as a one-hot grant plus its index.
module hb_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  // Scan from ptr upward; the first requester seen blocks all later ones.
  always_comb begin : scan_blk
    logic          found_s;
    logic          take_s;
    logic [IW-1:0] pos_s;
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    take_s  = 1'b0;
    pos_s   = '0;
    for (int k = 0; k < N; k++) begin
      pos_s        = IW'((int'(ptr) + k) % N);
      take_s       = req[pos_s] & ~found_s;
      grant[pos_s] = take_s;
      idx          = take_s ? pos_s : idx;
      found_s      = found_s | req[pos_s];
    end
  end

endmodule

// File: rtl/hb_task_scheduler.sv
// Task scheduler: round-robin producer push into an external queue and a
// two-state dispatcher handing queue heads to idle workers round-robin.
module hb_task_scheduler
  import hb_task_pkg::*;
#(
  parameter int NUM_PROD = 4,
  parameter int NUM_WORK = 4,
  parameter int WIDTH    = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_PROD-1:0]       prod_req,
  input  logic [NUM_PROD*WIDTH-1:0] prod_data,
  output logic [NUM_PROD-1:0]       prod_grant,
  output logic                      q_push_req,
  output logic [WIDTH-1:0]          q_data_in,
  input  logic                      q_full,
  input  logic                      q_valid,
  input  logic [WIDTH-1:0]          q_data,
  output logic                      q_pop_req,
  output logic [NUM_WORK-1:0]       wk_valid,
  output logic [WIDTH-1:0]          wk_data,
  input  logic [NUM_WORK-1:0]       wk_ready,
  input  logic [NUM_WORK-1:0]       wk_done,
  input  logic                      dispatch_en,
  output logic [NUM_WORK-1:0]       busy_mask,
  output logic [CNT_W-1:0]          dispatch_cnt
);

  localparam int PW = $clog2(NUM_PROD);
  localparam int WW = $clog2(NUM_WORK);
  localparam logic [PW-1:0] PROD_LAST = PW'(NUM_PROD - 1);
  localparam logic [WW-1:0] WORK_LAST = WW'(NUM_WORK - 1);

  logic [NUM_PROD-1:0] prod_req_s;
  logic [NUM_PROD-1:0] prod_grant_s;
  logic [PW-1:0]       prod_idx_s;
  logic [PW-1:0]       rr_prod_ptr_r;
  logic [NUM_WORK-1:0] work_grant_s;
  logic [WW-1:0]       work_idx_s;
  logic [WW-1:0]       rr_work_ptr_r;
  disp_state_e         state_r;
  disp_state_e         state_next_s;
  logic                pop_s;
  logic                hs_s;
  logic [NUM_WORK-1:0] wk_valid_s;
  logic [NUM_WORK-1:0] busy_r;
  logic [NUM_WORK-1:0] busy_next_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [WIDTH-1:0]    task_r;
  logic [WW-1:0]       task_idx_r;
  logic [WIDTH-1:0]    push_data_s;

  // Producers only compete while the queue can take a word and not in reset.
  always_comb begin
    if (reset || q_full) begin
      prod_req_s = '0;
    end else begin
      prod_req_s = prod_req;
    end
  end

  hb_rr_arbiter #(.N(NUM_PROD), .IW(PW)) u_prod_arb (
    .req   (prod_req_s),
    .ptr   (rr_prod_ptr_r),
    .grant (prod_grant_s),
    .idx   (prod_idx_s)
  );

  hb_rr_arbiter #(.N(NUM_WORK), .IW(WW)) u_work_arb (
    .req   (~busy_r),
    .ptr   (rr_work_ptr_r),
    .grant (work_grant_s),
    .idx   (work_idx_s)
  );

  // One-hot AND-OR mux of producer words; zero when nobody is granted.
  always_comb begin
    push_data_s = '0;
    for (int i = 0; i < NUM_PROD; i++) begin
      push_data_s = push_data_s | ({WIDTH{prod_grant_s[i]}} & prod_data[i*WIDTH +: WIDTH]);
    end
  end

  // Dispatcher next-state and strobes; pop happens in the same cycle as the decision.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    hs_s         = 1'b0;
    wk_valid_s   = '0;
    if (reset) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (dispatch_en && q_valid && (|work_grant_s)) begin
            pop_s        = 1'b1;
            state_next_s = ISSUE;
          end else begin
            state_next_s = IDLE;
          end
        end
        ISSUE: begin
          wk_valid_s[task_idx_r] = 1'b1;
          if (wk_ready[task_idx_r]) begin
            hs_s         = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = ISSUE;
          end
        end
        default: begin
          state_next_s = IDLE;
        end
      endcase
    end
  end

  // Completion clears a busy bit, but a same-cycle handoff to that worker wins.
  always_comb begin
    busy_next_s = busy_r & ~wk_done;
    if (hs_s) begin
      busy_next_s[task_idx_r] = 1'b1;
    end else begin
      busy_next_s = busy_next_s;
    end
  end

  // State, pointers, latched task and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      rr_prod_ptr_r <= '0;
      rr_work_ptr_r <= '0;
      busy_r        <= '0;
      cnt_r         <= '0;
      task_r        <= '0;
      task_idx_r    <= '0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= busy_next_s;
      if (|prod_grant_s) begin
        rr_prod_ptr_r <= (prod_idx_s == PROD_LAST) ? '0 : prod_idx_s + 1'b1;
      end
      if (pop_s) begin
        task_r     <= q_data;
        task_idx_r <= work_idx_s;
      end
      if (hs_s) begin
        cnt_r         <= cnt_r + CNT_W'(1);
        rr_work_ptr_r <= (task_idx_r == WORK_LAST) ? '0 : task_idx_r + 1'b1;
      end
    end
  end

  assign prod_grant   = prod_grant_s;
  assign q_push_req   = |prod_grant_s;
  assign q_data_in    = push_data_s;
  assign q_pop_req    = pop_s;
  assign wk_valid     = wk_valid_s;
  assign wk_data      = task_r;
  assign busy_mask    = busy_r;
  assign dispatch_cnt = cnt_r;

endmodule

// File: tb/tb_hb_task_scheduler.sv
// Self-checking bench for hb_task_scheduler: cycle model of arbitration and
// dispatch plus a scoreboard of popped tasks matched against worker handoffs.
module tb_hb_task_scheduler;

  logic         clk;
  logic         reset;
  logic [3:0]   prod_req;
  logic [127:0] prod_data;
  logic [3:0]   prod_grant;
  logic         q_push_req;
  logic [31:0]  q_data_in;
  logic         q_full;
  logic         q_valid;
  logic [31:0]  q_data;
  logic         q_pop_req;
  logic [3:0]   wk_valid;
  logic [31:0]  wk_data;
  logic [3:0]   wk_ready;
  logic [3:0]   wk_done;
  logic         dispatch_en;
  logic [3:0]   busy_mask;
  logic [15:0]  dispatch_cnt;

  logic [31:0]  pw [4];
  assign prod_data = {pw[3], pw[2], pw[1], pw[0]};

  hb_task_scheduler #(.NUM_PROD(4), .NUM_WORK(4), .WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .prod_req     (prod_req),
    .prod_data    (prod_data),
    .prod_grant   (prod_grant),
    .q_push_req   (q_push_req),
    .q_data_in    (q_data_in),
    .q_full       (q_full),
    .q_valid      (q_valid),
    .q_data       (q_data),
    .q_pop_req    (q_pop_req),
    .wk_valid     (wk_valid),
    .wk_data      (wk_data),
    .wk_ready     (wk_ready),
    .wk_done      (wk_done),
    .dispatch_en  (dispatch_en),
    .busy_mask    (busy_mask),
    .dispatch_cnt (dispatch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  w;
  } sb_t;

  sb_t         sb [$];
  logic [31:0] tq [$];

  int n_chk = 0;
  int n_bad = 0;

  // model state
  logic [1:0]  m_pptr, m_wptr, m_idx;
  logic        m_issue;
  logic [3:0]  m_busy;
  logic [15:0] m_cnt;

  // values sampled at the last negedge
  logic [3:0]  s_grant, s_wkv;
  logic        s_push, s_pop;
  logic [31:0] s_wkd;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] rr4(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] j;
    for (int k = 0; k < 4; k++) begin
      j = ptr + 2'(k);
      if (req[j]) return 4'b0001 << j;
    end
    return 4'b0000;
  endfunction

  function automatic logic [1:0] oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) return 2'(i);
    end
    return 2'd0;
  endfunction

  task automatic cyc();
    logic [3:0]  eg, ew, nb, sel;
    logic [31:0] ed;
    logic        ep, hs;
    sb_t         e;
    q_valid = (tq.size() != 0);
    q_data  = q_valid ? tq[0] : 32'h0;
    @(negedge clk);
    s_grant = prod_grant;
    s_push  = q_push_req;
    s_pop   = q_pop_req;
    s_wkv   = wk_valid;
    s_wkd   = wk_data;
    eg = (reset || q_full) ? 4'b0000 : rr4(prod_req, m_pptr);
    ed = (eg != 4'b0000) ? pw[oh2i(eg)] : 32'h0;
    chk_eq("prod_grant", prod_grant, eg);
    chk_eq("q_push_req", q_push_req, |eg);
    chk_eq("q_data_in", q_data_in, ed);
    ep = !reset && !m_issue && dispatch_en && q_valid && (m_busy != 4'hF);
    chk_eq("q_pop_req", q_pop_req, ep);
    ew = (!reset && m_issue) ? (4'b0001 << m_idx) : 4'b0000;
    chk_eq("wk_valid", wk_valid, ew);
    chk_eq("busy_mask", busy_mask, m_busy);
    chk_eq("dispatch_cnt", dispatch_cnt, m_cnt);
    hs = !reset && m_issue && wk_ready[m_idx];
    if (hs) begin
      chk_eq("sb_nonempty", sb.size() != 0, 1'b1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk_eq("hs_data", wk_data, e.d);
        chk_eq("hs_worker", wk_valid, 4'b0001 << e.w);
      end
    end
    @(posedge clk);
    #1;
    if (reset) begin
      m_pptr = 2'd0; m_wptr = 2'd0; m_idx = 2'd0;
      m_issue = 1'b0; m_busy = 4'h0; m_cnt = 16'd0;
      sb.delete();
    end else begin
      if (eg != 4'b0000) m_pptr = oh2i(eg) + 2'd1;
      nb = m_busy & ~wk_done;
      if (hs) begin
        nb[m_idx] = 1'b1;
        m_cnt     = m_cnt + 16'd1;
        m_wptr    = m_idx + 2'd1;
        m_issue   = 1'b0;
      end
      if (ep) begin
        sel = rr4(~m_busy, m_wptr);
        e.d = q_data;
        e.w = oh2i(sel);
        sb.push_back(e);
        m_idx   = e.w;
        m_issue = 1'b1;
        void'(tq.pop_front());
      end
      m_busy = nb;
    end
    wk_done = 4'b0000;
  endtask

  logic [3:0]  g_exp [4];
  logic        pop_log [5];
  logic [3:0]  wkv_log [5];
  logic [31:0] wkd_log [5];
  int          npush;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; prod_req = 4'hF; q_full = 1'b0; q_valid = 1'b0; q_data = 32'h0;
    wk_ready = 4'h0; wk_done = 4'h0; dispatch_en = 1'b0;
    pw[0] = 32'h1000_0000; pw[1] = 32'h1100_0011; pw[2] = 32'h1200_0022; pw[3] = 32'h1300_0033;
    m_pptr = 2'd0; m_wptr = 2'd0; m_idx = 2'd0; m_issue = 1'b0; m_busy = 4'h0; m_cnt = 16'd0;
    g_exp[0] = 4'b0001; g_exp[1] = 4'b0010; g_exp[2] = 4'b0100; g_exp[3] = 4'b1000;
    @(posedge clk);
    #1;
    // reset held: all strobes gated
    cyc();
    cyc();
    chk_eq("rst_grant", s_grant, 4'b0000);
    chk_eq("rst_push", s_push, 1'b0);

    // four producers rotate one grant per cycle from pointer 0
    reset = 1'b0;
    npush = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk_eq("p1_grant", s_grant, g_exp[i]);
      npush += int'(s_push);
    end
    chk_eq("p1_pushes", npush, 4);

    // full queue blocks, release grants producer 0 in the same cycle
    q_full = 1'b1; prod_req = 4'b0101;
    cyc();
    chk_eq("full_grant", s_grant, 4'b0000);
    chk_eq("full_push", s_push, 1'b0);
    q_full = 1'b0;
    cyc();
    chk_eq("unfull_grant", s_grant, 4'b0001);
    prod_req = 4'b0000;

    // two tasks, all workers ready: A to worker 0 at T+1, B to worker 1 at T+3
    dispatch_en = 1'b1; wk_ready = 4'hF;
    tq.push_back(32'hAAAA_0001);
    tq.push_back(32'hBBBB_0002);
    for (int i = 0; i < 5; i++) begin
      cyc();
      pop_log[i] = s_pop; wkv_log[i] = s_wkv; wkd_log[i] = s_wkd;
    end
    chk_eq("ab_pop0", pop_log[0], 1'b1);
    chk_eq("ab_wkv1", wkv_log[1], 4'b0001);
    chk_eq("ab_wkd1", wkd_log[1], 32'hAAAA_0001);
    chk_eq("ab_pop2", pop_log[2], 1'b1);
    chk_eq("ab_wkv3", wkv_log[3], 4'b0010);
    chk_eq("ab_wkd3", wkd_log[3], 32'hBBBB_0002);
    chk_eq("ab_busy", busy_mask, 4'b0011);
    chk_eq("ab_cnt", dispatch_cnt, 16'd2);

    // fill workers 2 and 3, then a third task waits until worker 2 completes
    tq.push_back(32'hCCCC_0003);
    tq.push_back(32'hDDDD_0004);
    tq.push_back(32'hEEEE_0005);
    for (int i = 0; i < 4; i++) cyc();
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk_eq("allbusy_pop", s_pop, 1'b0);
    end
    chk_eq("allbusy_mask", busy_mask, 4'b1111);
    wk_done = 4'b0100;
    cyc();
    chk_eq("done_T_pop", s_pop, 1'b0);
    cyc();
    chk_eq("done_T1_pop", s_pop, 1'b1);
    cyc();
    chk_eq("done_T2_wkv", s_wkv, 4'b0100);
    chk_eq("done_T2_wkd", s_wkd, 32'hEEEE_0005);

    // stall in ISSUE with dispatch_en dropped; done coincides with handshake
    wk_done = 4'b1111; wk_ready = 4'b0000;
    tq.push_back(32'hFFFF_0006);
    cyc();
    chk_eq("stall_pre_pop", s_pop, 1'b0);
    cyc();
    chk_eq("stall_pop", s_pop, 1'b1);
    dispatch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_eq("stall_wkv", s_wkv, 4'b1000);
      chk_eq("stall_wkd", s_wkd, 32'hFFFF_0006);
    end
    wk_ready = 4'hF; wk_done = 4'b1000;
    cyc();
    chk_eq("stall_hs_wkv", s_wkv, 4'b1000);
    chk_eq("setwins_busy", busy_mask, 4'b1000);
    tq.push_back(32'h6666_0007);
    wk_done = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_eq("disabled_pop", s_pop, 1'b0);
    end
    chk_eq("ignore_done_busy", busy_mask, 4'b1000);
    chk_eq("stall_cnt", dispatch_cnt, 16'd6);

    // push and pop together, then reset in the middle of ISSUE
    dispatch_en = 1'b1; wk_ready = 4'h0; prod_req = 4'b0010;
    cyc();
    chk_eq("pp_pop", s_pop, 1'b1);
    chk_eq("pp_grant", s_grant, 4'b0010);
    prod_req = 4'b0000;
    cyc();
    chk_eq("rstiss_wkv", s_wkv, 4'b0001);
    chk_eq("rstiss_wkd", s_wkd, 32'h6666_0007);
    reset = 1'b1;
    cyc();
    chk_eq("rstiss_gated", s_wkv, 4'b0000);
    reset = 1'b0;
    cyc();
    chk_eq("post_rst_wkv", s_wkv, 4'b0000);
    chk_eq("post_rst_busy", busy_mask, 4'b0000);
    chk_eq("post_rst_cnt", dispatch_cnt, 16'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
